// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg: shared state encoding and timer sizing for the combo lock
package combo_lock_pkg;
    typedef enum logic [1:0] {LOCKED, UNLOCKED, PROGRAM, LOCKOUT} state_e;
    function automatic int timer_w(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction
endpackage

// File: rtl/combo_lock_if.sv
// combo_lock_if: keypad-side inputs and status outputs of the combo lock
interface combo_lock_if #(
    parameter int DIGIT_W = 4,
    parameter int FC_W = 2,
    parameter int EP_W = 3
);
    logic digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic clear;
    logic unlocked;
    logic prog_active;
    logic lockout;
    logic [FC_W-1:0] fail_count;
    logic [EP_W-1:0] entry_pos;
    logic code_changed;
    modport master (
        output digit_valid, digit, clear,
        input unlocked, prog_active, lockout, fail_count, entry_pos, code_changed
    );
    modport slave (
        input digit_valid, digit, clear,
        output unlocked, prog_active, lockout, fail_count, entry_pos, code_changed
    );
endinterface

// File: rtl/lock_timer.sv
// lock_timer: loadable saturating down-counter, expire pulses while enabled at count 1
module lock_timer #(
    parameter int WIDTH = 6
) (
    input logic clk,
    input logic reset,
    input logic load_i,
    input logic [WIDTH-1:0] val_i,
    input logic en_i,
    output logic expire_o
);
    logic [WIDTH-1:0] cnt_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    assign expire_o = en_i && !load_i && cnt_q == WIDTH'(1);
endmodule

// File: rtl/combo_lock_core.sv
// combo_lock_core: digit-sequence lock with programmable code, fail counting and timed lockout
module combo_lock_core
    import combo_lock_pkg::*;
#(
    parameter int DIGIT_W = 4,
    parameter int CODE_LEN = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int MAX_TRIES = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int AUTO_RELOCK_CYCLES = 32,
    parameter logic [DIGIT_W-1:0] CMD_LOCK = 4'hA,
    parameter logic [DIGIT_W-1:0] CMD_PROG = 4'hB
) (
    input logic clk,
    input logic reset,
    combo_lock_if.slave bus
);
    localparam int CW = CODE_LEN * DIGIT_W;
    localparam int TW = timer_w(LOCKOUT_CYCLES, AUTO_RELOCK_CYCLES);
    localparam int FC_W = $clog2(MAX_TRIES + 1);
    localparam int EP_W = $clog2(CODE_LEN + 1);
    localparam logic [FC_W-1:0] MAXT = FC_W'(MAX_TRIES);
    localparam logic [EP_W-1:0] LAST = EP_W'(CODE_LEN - 1);
    state_e state_q, state_d;
    logic [CW-1:0] code_q, code_d, shadow_q, shadow_d, sh_w;
    logic [FC_W-1:0] fail_q, fail_d;
    logic [EP_W-1:0] pos_q, pos_d;
    logic mis_q, mis_d, chg_q, chg_d;
    logic rl_load, lo_load, rl_exp, lo_exp, miss, last;
    assign last = pos_q == LAST;
    assign miss = mis_q || bus.digit != code_q[DIGIT_W*(CODE_LEN-1-int'(pos_q)) +: DIGIT_W];
    lock_timer #(.WIDTH(TW)) u_relock (
        .clk(clk), .reset(reset), .load_i(rl_load), .val_i(TW'(AUTO_RELOCK_CYCLES)),
        .en_i(state_q == UNLOCKED || state_q == PROGRAM), .expire_o(rl_exp)
    );
    lock_timer #(.WIDTH(TW)) u_lockout (
        .clk(clk), .reset(reset), .load_i(lo_load), .val_i(TW'(LOCKOUT_CYCLES)),
        .en_i(state_q == LOCKOUT), .expire_o(lo_exp)
    );
    always_comb begin
        state_d = state_q;
        code_d = code_q;
        shadow_d = shadow_q;
        fail_d = fail_q;
        pos_d = pos_q;
        mis_d = mis_q;
        chg_d = 1'b0;
        rl_load = 1'b0;
        lo_load = 1'b0;
        sh_w = shadow_q;
        sh_w[DIGIT_W*(CODE_LEN-1-int'(pos_q)) +: DIGIT_W] = bus.digit;
        case (state_q)
            LOCKED:
                if (bus.clear) begin
                    pos_d = '0;
                    mis_d = 1'b0;
                end else if (bus.digit_valid) begin
                    pos_d = last ? '0 : pos_q + 1'b1;
                    mis_d = last ? 1'b0 : miss;
                    if (last && !miss) begin
                        state_d = UNLOCKED;
                        fail_d = '0;
                        rl_load = 1'b1;
                    end else if (last) begin
                        fail_d = fail_q + 1'b1;
                        state_d = fail_q + 1'b1 == MAXT ? LOCKOUT : LOCKED;
                        lo_load = fail_q + 1'b1 == MAXT;
                    end
                end
            UNLOCKED:
                if (bus.digit_valid) begin
                    rl_load = 1'b1;
                    state_d = bus.digit == CMD_LOCK ? LOCKED : bus.digit == CMD_PROG ? PROGRAM : UNLOCKED;
                    pos_d = '0;
                end else if (rl_exp) state_d = LOCKED;
            PROGRAM:
                if (bus.clear) begin
                    state_d = UNLOCKED;
                    pos_d = '0;
                    rl_load = 1'b1;
                end else if (bus.digit_valid) begin
                    rl_load = 1'b1;
                    shadow_d = sh_w;
                    pos_d = last ? '0 : pos_q + 1'b1;
                    code_d = last ? sh_w : code_q;
                    chg_d = last;
                    state_d = last ? LOCKED : PROGRAM;
                end else if (rl_exp) begin
                    state_d = LOCKED;
                    pos_d = '0;
                end
            LOCKOUT:
                if (lo_exp) begin
                    state_d = LOCKED;
                    fail_d = '0;
                end
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= LOCKED;
            code_q <= DEFAULT_CODE;
            shadow_q <= '0;
            fail_q <= '0;
            pos_q <= '0;
            mis_q <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q <= code_d;
            shadow_q <= shadow_d;
            fail_q <= fail_d;
            pos_q <= pos_d;
            mis_q <= mis_d;
            chg_q <= chg_d;
        end
    assign bus.unlocked = state_q == UNLOCKED;
    assign bus.prog_active = state_q == PROGRAM;
    assign bus.lockout = state_q == LOCKOUT;
    assign bus.fail_count = fail_q;
    assign bus.entry_pos = pos_q;
    assign bus.code_changed = chg_q;
endmodule

// File: tb/tb_combo_lock_core.sv
// tb_combo_lock_core: directed vector table plus multi-cycle sequences for the combo lock
module tb_combo_lock_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    typedef struct {
        logic dv;
        logic [3:0] d;
        logic clr;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs[$];
    combo_lock_if #(.DIGIT_W(4), .FC_W(2), .EP_W(3)) bus ();
    combo_lock_core dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [8:0] e(input logic u, input logic p, input logic l, input logic [1:0] f, input logic [2:0] pos, input logic c);
        return {u, p, l, f, pos, c};
    endfunction
    function automatic logic [8:0] outs();
        return {bus.unlocked, bus.prog_active, bus.lockout, bus.fail_count, bus.entry_pos, bus.code_changed};
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic add(input logic dv, input logic [3:0] d, input logic clr, input logic [8:0] exp);
        vecs.push_back('{dv, d, clr, exp});
    endtask
    task automatic step(input logic dv, input logic [3:0] d, input logic clr);
        bus.digit_valid = dv;
        bus.digit = d;
        bus.clear = clr;
        @(posedge clk);
        #1;
        bus.digit_valid = 1'b0;
        bus.clear = 1'b0;
    endtask
    task automatic enter(input logic [15:0] code);
        for (int i = 0; i < 4; i++) step(1'b1, code[15-4*i -: 4], 1'b0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int cnt;
        int pulses;
        bus.digit_valid = 1'b0;
        bus.digit = '0;
        bus.clear = 1'b0;
        add(1, 4'h1, 0, e(0, 0, 0, 0, 1, 0));
        add(1, 4'h2, 0, e(0, 0, 0, 0, 2, 0));
        add(1, 4'h3, 0, e(0, 0, 0, 0, 3, 0));
        add(1, 4'h4, 0, e(1, 0, 0, 0, 0, 0));
        add(0, 4'h0, 0, e(1, 0, 0, 0, 0, 0));
        add(1, 4'h5, 0, e(1, 0, 0, 0, 0, 0));
        add(0, 4'h0, 1, e(1, 0, 0, 0, 0, 0));
        add(1, 4'hA, 0, e(0, 0, 0, 0, 0, 0));
        add(1, 4'h1, 0, e(0, 0, 0, 0, 1, 0));
        add(1, 4'h9, 0, e(0, 0, 0, 0, 2, 0));
        add(1, 4'h3, 0, e(0, 0, 0, 0, 3, 0));
        add(1, 4'h4, 0, e(0, 0, 0, 1, 0, 0));
        add(1, 4'h1, 0, e(0, 0, 0, 1, 1, 0));
        add(1, 4'h2, 0, e(0, 0, 0, 1, 2, 0));
        add(1, 4'h7, 1, e(0, 0, 0, 1, 0, 0));
        add(1, 4'h1, 0, e(0, 0, 0, 1, 1, 0));
        add(1, 4'h2, 0, e(0, 0, 0, 1, 2, 0));
        add(1, 4'h3, 0, e(0, 0, 0, 1, 3, 0));
        add(1, 4'h4, 0, e(1, 0, 0, 0, 0, 0));
        add(1, 4'hB, 0, e(0, 1, 0, 0, 0, 0));
        add(1, 4'h5, 0, e(0, 1, 0, 0, 1, 0));
        add(1, 4'h6, 0, e(0, 1, 0, 0, 2, 0));
        add(0, 4'h0, 1, e(1, 0, 0, 0, 0, 0));
        add(1, 4'hA, 0, e(0, 0, 0, 0, 0, 0));
        add(1, 4'h1, 0, e(0, 0, 0, 0, 1, 0));
        add(1, 4'h2, 0, e(0, 0, 0, 0, 2, 0));
        add(1, 4'h3, 0, e(0, 0, 0, 0, 3, 0));
        add(1, 4'h4, 0, e(1, 0, 0, 0, 0, 0));
        add(1, 4'hA, 0, e(0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'(e(0, 0, 0, 0, 0, 0)));
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].dv, vecs[i].d, vecs[i].clr);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        enter(16'h1934);
        chk("fail1", 32'(outs()), 32'(e(0, 0, 0, 1, 0, 0)));
        enter(16'h1934);
        enter(16'h1934);
        chk("lockout_enter", 32'(outs()), 32'(e(0, 0, 1, 3, 0, 0)));
        cnt = 1;
        for (int k = 0; k < 40 && bus.lockout; k++) begin
            step(1'b1, 4'h1, 1'b0);
            if (bus.lockout) cnt++;
        end
        chk("lockout_len", cnt, 16);
        chk("after_lockout", 32'(outs()), 32'(e(0, 0, 0, 0, 0, 0)));
        enter(16'h1234);
        chk("unlock_after_lockout", 32'(outs()), 32'(e(1, 0, 0, 0, 0, 0)));
        pulses = 0;
        step(1'b1, 4'hB, 1'b0);
        chk("prog_enter", 32'(outs()), 32'(e(0, 1, 0, 0, 0, 0)));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'(5 + i), 1'b0);
            pulses += int'(bus.code_changed);
        end
        chk("commit", 32'(outs()), 32'(e(0, 0, 0, 0, 0, 1)));
        repeat (2) begin
            step(1'b0, 4'h0, 1'b0);
            pulses += int'(bus.code_changed);
        end
        chk("commit_pulses", pulses, 1);
        enter(16'h1234);
        chk("old_code_fails", 32'(outs()), 32'(e(0, 0, 0, 1, 0, 0)));
        enter(16'h5678);
        chk("new_code_unlocks", 32'(outs()), 32'(e(1, 0, 0, 0, 0, 0)));
        for (int k = 1; k <= 32; k++) begin
            step(1'b0, 4'h0, 1'b0);
            chk($sformatf("relock_idle_%0d", k), 32'(bus.unlocked), 32'(k < 32));
        end
        enter(16'h5678);
        for (int k = 1; k <= 52; k++) begin
            step(k == 20, 4'h7, 1'b0);
            chk($sformatf("relock_ext_%0d", k), 32'(bus.unlocked), 32'(k < 52));
        end
        enter(16'h5678);
        step(1'b1, 4'hB, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        chk("mid_prog", 32'(outs()), 32'(e(0, 1, 0, 0, 2, 0)));
        #2 reset = 1'b1;
        #1 chk("async_reset", 32'(outs()), 32'(e(0, 0, 0, 0, 0, 0)));
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        enter(16'h1234);
        chk("default_restored", 32'(outs()), 32'(e(1, 0, 0, 0, 0, 0)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
